// File: rtl/wb_dcache_vc_ctrl_pkg.sv
// Shared types and defaults for the write-back dcache controller
// with victim-cache swap/write-back path.
package wb_dcache_vc_ctrl_pkg;

  localparam int unsigned DEF_IDX_BITS    = 7;
  localparam int unsigned DEF_VC_IDX_BITS = 2;
  localparam int unsigned DEF_BEATS       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_VC_SWAP,
    S_WB,
    S_ALLOC,
    S_FLUSH_CHK,
    S_FLUSH_NEXT,
    S_FLUSH_DONE
  } type_dcache_vc_states_e;

  typedef enum logic {
    PH_MAIN,
    PH_VC
  } type_flush_phase_e;

  // Beat index width, at least one bit even for single-beat lines.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/wb_dcache_vc_ctrl_if.sv
// Request, datapath and memory-port bundle of the dcache controller.
// slave: the controller; master: the surrounding LSU/datapath/memory.
interface wb_dcache_vc_ctrl_if
  import wb_dcache_vc_ctrl_pkg::*;
#(
  parameter int unsigned IDX_BITS    = DEF_IDX_BITS,
  parameter int unsigned VC_IDX_BITS = DEF_VC_IDX_BITS,
  parameter int unsigned BEATS       = DEF_BEATS
) ();
  localparam int unsigned BW = beat_w(BEATS);

  logic                   lsummu2dcache_req_i;
  logic                   lsummu2dcache_wr_i;
  logic                   dmem_sel_i;
  logic                   dcache_kill_i;
  logic                   dcache_flush_i;
  logic                   dcache2lsummu_ack_o;
  logic                   cache_hit_i;
  logic                   line_valid_i;
  logic                   main_dirty_i;
  logic                   vc_hit_i;
  logic                   vc_evict_dirty_i;
  logic                   vc_dirty_i;
  logic                   mem2dcache_ack_i;
  logic                   cache_wr_o;
  logic                   cache_line_wr_o;
  logic                   cache_line_clean_o;
  logic                   vc_clean_o;
  logic                   vc_swap_o;
  logic                   vc_insert_o;
  logic                   wb_src_vc_o;
  logic [BW-1:0]          beat_idx_o;
  logic [IDX_BITS-1:0]    evict_index_o;
  logic [VC_IDX_BITS-1:0] vc_index_o;
  logic                   dcache2mem_req_o;
  logic                   dcache2mem_wr_o;
  logic                   dcache2mem_kill_o;

  modport slave (
    input  lsummu2dcache_req_i, lsummu2dcache_wr_i, dmem_sel_i,
    input  dcache_kill_i, dcache_flush_i,
    input  cache_hit_i, line_valid_i, main_dirty_i,
    input  vc_hit_i, vc_evict_dirty_i, vc_dirty_i,
    input  mem2dcache_ack_i,
    output dcache2lsummu_ack_o,
    output cache_wr_o, cache_line_wr_o, cache_line_clean_o, vc_clean_o,
    output vc_swap_o, vc_insert_o, wb_src_vc_o,
    output beat_idx_o, evict_index_o, vc_index_o,
    output dcache2mem_req_o, dcache2mem_wr_o, dcache2mem_kill_o
  );

  modport master (
    output lsummu2dcache_req_i, lsummu2dcache_wr_i, dmem_sel_i,
    output dcache_kill_i, dcache_flush_i,
    output cache_hit_i, line_valid_i, main_dirty_i,
    output vc_hit_i, vc_evict_dirty_i, vc_dirty_i,
    output mem2dcache_ack_i,
    input  dcache2lsummu_ack_o,
    input  cache_wr_o, cache_line_wr_o, cache_line_clean_o, vc_clean_o,
    input  vc_swap_o, vc_insert_o, wb_src_vc_o,
    input  beat_idx_o, evict_index_o, vc_index_o,
    input  dcache2mem_req_o, dcache2mem_wr_o, dcache2mem_kill_o
  );

endinterface

// File: rtl/wb_dcache_vc_ctrl_dcache_beat_counter.sv
// Counts acknowledged line beats; wraps to 0 only on the last-beat
// ack and flags the last beat of the line.
module dcache_beat_counter
  import wb_dcache_vc_ctrl_pkg::*;
#(
  parameter int unsigned BEATS = DEF_BEATS,
  localparam int unsigned BW   = beat_w(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [BW-1:0] cnt_o,
  output logic          last_o
);
  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;

  assign last_o = (cnt_q == BW'(BEATS - 1));
  assign cnt_o  = cnt_q;

  // Next count: clear on abort, advance on ack, wrap after last beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_dcache_vc_ctrl.sv
// Write-back dcache controller: lookup, VC swap, VC write-back on
// miss, multi-beat refill and a two-phase (main, then VC) flush walk.
module wb_dcache_vc_ctrl
  import wb_dcache_vc_ctrl_pkg::*;
#(
  parameter int unsigned IDX_BITS    = DEF_IDX_BITS,
  parameter int unsigned VC_IDX_BITS = DEF_VC_IDX_BITS,
  parameter int unsigned BEATS       = DEF_BEATS
) (
  input logic                clk,
  input logic                rst,
  wb_dcache_vc_ctrl_if.slave bus
);
  localparam int unsigned BW = beat_w(BEATS);
  localparam logic [IDX_BITS-1:0]    IDX_MAX = '1;
  localparam logic [VC_IDX_BITS-1:0] VC_MAX  = '1;

  type_dcache_vc_states_e state_q, state_d;
  type_flush_phase_e      phase_q, phase_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [VC_IDX_BITS-1:0] vc_idx_q, vc_idx_d;
  logic wr_q, wr_d;
  logic sel_q, sel_d;
  logic miss_wb_q, miss_wb_d;
  logic src_vc_q, src_vc_d;

  logic          beat_inc, beat_clr, beat_last;
  logic [BW-1:0] beat_idx;

  logic ack, cwr, lwr, lcln, vcln, swap, ins;
  logic mreq, mwr, mkill;
  logic in_flush, sel_ok, abort, dirty_chk, ph_last;

  dcache_beat_counter #(
    .BEATS(BEATS)
  ) u_beats (
    .clk   (clk),
    .rst   (rst),
    .clr_i (beat_clr),
    .inc_i (beat_inc),
    .cnt_o (beat_idx),
    .last_o(beat_last)
  );

  // A write-back without miss_wb belongs to a flush walk.
  assign in_flush = (state_q == S_FLUSH_CHK)
                  | (state_q == S_FLUSH_NEXT)
                  | (state_q == S_FLUSH_DONE)
                  | ((state_q == S_WB) & ~miss_wb_q);
  assign sel_ok   = (state_q == S_LOOKUP) ? sel_q : bus.dmem_sel_i;
  assign abort    = (state_q != S_IDLE)
                  & (bus.dcache_kill_i | (~in_flush & ~sel_ok));

  assign dirty_chk = (phase_q == PH_VC) ? bus.vc_dirty_i
                                        : bus.main_dirty_i;
  assign ph_last   = (phase_q == PH_VC) ? (vc_idx_q == VC_MAX)
                                        : (idx_q == IDX_MAX);

  // Next-state and strobe decode; abort overrides everything last.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    vc_idx_d  = vc_idx_q;
    wr_d      = wr_q;
    sel_d     = sel_q;
    miss_wb_d = miss_wb_q;
    src_vc_d  = src_vc_q;
    beat_inc  = 1'b0;
    beat_clr  = 1'b0;
    ack       = 1'b0;
    cwr       = 1'b0;
    lwr       = 1'b0;
    lcln      = 1'b0;
    vcln      = 1'b0;
    swap      = 1'b0;
    ins       = 1'b0;
    mreq      = 1'b0;
    mwr       = 1'b0;
    mkill     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.dcache_flush_i) begin
          state_d  = S_FLUSH_CHK;
          phase_d  = PH_MAIN;
          idx_d    = '0;
          vc_idx_d = '0;
        end else if (bus.lsummu2dcache_req_i) begin
          state_d = S_LOOKUP;
          wr_d    = bus.lsummu2dcache_wr_i;
          sel_d   = bus.dmem_sel_i;
        end
      end
      S_LOOKUP: begin
        if (bus.cache_hit_i) begin
          ack     = 1'b1;
          cwr     = wr_q;
          state_d = S_IDLE;
        end else if (bus.vc_hit_i) begin
          swap    = 1'b1;
          state_d = S_VC_SWAP;
        end else if (bus.line_valid_i && bus.vc_evict_dirty_i) begin
          state_d   = S_WB;
          src_vc_d  = 1'b1;
          miss_wb_d = 1'b1;
        end else begin
          ins     = bus.line_valid_i;
          state_d = S_ALLOC;
        end
      end
      S_VC_SWAP: begin
        ack     = 1'b1;
        cwr     = wr_q;
        state_d = S_IDLE;
      end
      S_WB: begin
        mreq     = 1'b1;
        mwr      = 1'b1;
        beat_inc = bus.mem2dcache_ack_i;
        if (bus.mem2dcache_ack_i && beat_last) begin
          src_vc_d = 1'b0;
          if (miss_wb_q) begin
            ins       = 1'b1;
            miss_wb_d = 1'b0;
            state_d   = S_ALLOC;
          end else begin
            state_d = S_FLUSH_NEXT;
            if (src_vc_q) begin
              vcln = 1'b1;
              if (vc_idx_q != VC_MAX) vc_idx_d = vc_idx_q + 1'b1;
            end else begin
              lcln = 1'b1;
              if (idx_q != IDX_MAX) idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      S_ALLOC: begin
        mreq = 1'b1;
        if (bus.mem2dcache_ack_i) begin
          lwr      = 1'b1;
          beat_inc = 1'b1;
          if (beat_last) state_d = S_LOOKUP;
        end
      end
      S_FLUSH_CHK: begin
        if (dirty_chk) begin
          state_d   = S_WB;
          src_vc_d  = (phase_q == PH_VC);
          miss_wb_d = 1'b0;
        end else if (ph_last) begin
          if (phase_q == PH_VC) begin
            state_d = S_FLUSH_DONE;
          end else begin
            phase_d = PH_VC;
            state_d = S_FLUSH_NEXT;
          end
        end else begin
          state_d = S_FLUSH_NEXT;
          if (phase_q == PH_VC) vc_idx_d = vc_idx_q + 1'b1;
          else                  idx_d    = idx_q + 1'b1;
        end
      end
      S_FLUSH_NEXT: begin
        state_d = S_FLUSH_CHK;
      end
      S_FLUSH_DONE: begin
        ack      = 1'b1;
        idx_d    = '0;
        vc_idx_d = '0;
        phase_d  = PH_MAIN;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      phase_d   = PH_MAIN;
      idx_d     = '0;
      vc_idx_d  = '0;
      miss_wb_d = 1'b0;
      src_vc_d  = 1'b0;
      beat_inc  = 1'b0;
      beat_clr  = 1'b1;
      ack       = 1'b0;
      cwr       = 1'b0;
      lwr       = 1'b0;
      lcln      = 1'b0;
      vcln      = 1'b0;
      swap      = 1'b0;
      ins       = 1'b0;
      mreq      = 1'b0;
      mwr       = 1'b0;
      mkill     = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_MAIN;
      idx_q     <= '0;
      vc_idx_q  <= '0;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      miss_wb_q <= 1'b0;
      src_vc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      vc_idx_q  <= vc_idx_d;
      wr_q      <= wr_d;
      sel_q     <= sel_d;
      miss_wb_q <= miss_wb_d;
      src_vc_q  <= src_vc_d;
    end
  end

  assign bus.dcache2lsummu_ack_o = ack;
  assign bus.cache_wr_o          = cwr;
  assign bus.cache_line_wr_o     = lwr;
  assign bus.cache_line_clean_o  = lcln;
  assign bus.vc_clean_o          = vcln;
  assign bus.vc_swap_o           = swap;
  assign bus.vc_insert_o         = ins;
  assign bus.wb_src_vc_o         = src_vc_q;
  assign bus.beat_idx_o          = beat_idx;
  assign bus.evict_index_o       = idx_q;
  assign bus.vc_index_o          = vc_idx_q;
  assign bus.dcache2mem_req_o    = mreq;
  assign bus.dcache2mem_wr_o     = mwr;
  assign bus.dcache2mem_kill_o   = mkill;

endmodule

// File: tb/tb_wb_dcache_vc_ctrl.sv
// Directed bench for wb_dcache_vc_ctrl: per-cycle vector table plus
// hand-written flush, abort and reset sequences.
module tb_wb_dcache_vc_ctrl;

  localparam int unsigned IB = 2;
  localparam int unsigned VB = 1;
  localparam int unsigned NB = 4;

  localparam logic [11:0] NOIN  = 12'h000;
  localparam logic [11:0] REQ   = 12'h800;
  localparam logic [11:0] WR    = 12'h400;
  localparam logic [11:0] SEL   = 12'h200;
  localparam logic [11:0] KILL  = 12'h100;
  localparam logic [11:0] FLUSH = 12'h080;
  localparam logic [11:0] HIT   = 12'h040;
  localparam logic [11:0] LV    = 12'h020;
  localparam logic [11:0] MDRT  = 12'h010;
  localparam logic [11:0] VCHIT = 12'h008;
  localparam logic [11:0] VCEVD = 12'h004;
  localparam logic [11:0] VCDRT = 12'h002;
  localparam logic [11:0] MACK  = 12'h001;

  localparam logic [15:0] NONE  = 16'h0000;
  localparam logic [15:0] ACK   = 16'h0400;
  localparam logic [15:0] CWR   = 16'h0200;
  localparam logic [15:0] LWR   = 16'h0100;
  localparam logic [15:0] LCLN  = 16'h0080;
  localparam logic [15:0] VCLN  = 16'h0040;
  localparam logic [15:0] SWAP  = 16'h0020;
  localparam logic [15:0] INS   = 16'h0010;
  localparam logic [15:0] SRC   = 16'h0008;
  localparam logic [15:0] MREQ  = 16'h0004;
  localparam logic [15:0] MWR   = 16'h0002;
  localparam logic [15:0] MKILL = 16'h0001;

  function automatic logic [15:0] B(input int n);
    return 16'(n) << 11;
  endfunction
  function automatic logic [15:0] VI(input int n);
    return 16'(n) << 13;
  endfunction
  function automatic logic [15:0] EI(input int n);
    return 16'(n) << 14;
  endfunction

  typedef struct {
    logic [11:0] in;
    logic [15:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  vec_t tbl[$];
  logic [15:0] obs;

  wb_dcache_vc_ctrl_if #(
    .IDX_BITS(IB), .VC_IDX_BITS(VB), .BEATS(NB)
  ) bus ();

  wb_dcache_vc_ctrl #(
    .IDX_BITS(IB), .VC_IDX_BITS(VB), .BEATS(NB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.evict_index_o, bus.vc_index_o, bus.beat_idx_o,
                bus.dcache2lsummu_ack_o, bus.cache_wr_o,
                bus.cache_line_wr_o, bus.cache_line_clean_o,
                bus.vc_clean_o, bus.vc_swap_o, bus.vc_insert_o,
                bus.wb_src_vc_o, bus.dcache2mem_req_o,
                bus.dcache2mem_wr_o, bus.dcache2mem_kill_o};

  task automatic drive(input logic [11:0] in);
    bus.lsummu2dcache_req_i = in[11];
    bus.lsummu2dcache_wr_i  = in[10];
    bus.dmem_sel_i          = in[9];
    bus.dcache_kill_i       = in[8];
    bus.dcache_flush_i      = in[7];
    bus.cache_hit_i         = in[6];
    bus.line_valid_i        = in[5];
    bus.main_dirty_i        = in[4];
    bus.vc_hit_i            = in[3];
    bus.vc_evict_dirty_i    = in[2];
    bus.vc_dirty_i          = in[1];
    bus.mem2dcache_ack_i    = in[0];
  endtask

  task automatic check(input string nm, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %h, expected %h", nm, obs, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic apply(input logic [11:0] in, input logic [15:0] exp,
                       input string nm);
    @(negedge clk);
    drive(in);
    #1;
    check(nm, exp);
  endtask

  initial begin
    logic mdirty[4];
    logic vdirty[2];
    int   acks, cleans, kills, lc_idx, vc_idx;
    bit   done;

    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(NOIN);

    // read hit
    tbl.push_back('{REQ|SEL, NONE});
    tbl.push_back('{SEL|HIT, ACK});
    tbl.push_back('{SEL, NONE});
    // VC write hit
    tbl.push_back('{REQ|WR|SEL, NONE});
    tbl.push_back('{SEL|VCHIT, SWAP});
    tbl.push_back('{SEL, ACK|CWR});
    // main write hit
    tbl.push_back('{REQ|WR|SEL, NONE});
    tbl.push_back('{SEL|HIT, ACK|CWR});
    // miss, displaced VC slot dirty: write-back then refill
    tbl.push_back('{REQ|SEL, NONE});
    tbl.push_back('{SEL|LV|VCEVD, NONE});
    tbl.push_back('{SEL, MREQ|MWR|SRC|B(0)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|B(0)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|B(1)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|B(2)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|B(3)|INS});
    tbl.push_back('{SEL|MACK, MREQ|LWR|B(0)});
    tbl.push_back('{SEL, MREQ|B(1)});
    tbl.push_back('{SEL|MACK, MREQ|LWR|B(1)});
    tbl.push_back('{SEL|MACK, MREQ|LWR|B(2)});
    tbl.push_back('{SEL|MACK, MREQ|LWR|B(3)});
    tbl.push_back('{SEL|HIT, ACK});
    tbl.push_back('{SEL|MACK, NONE});
    // clean miss with insert, killed at refill beat 2
    tbl.push_back('{REQ|SEL, NONE});
    tbl.push_back('{SEL|LV, INS});
    tbl.push_back('{SEL|MACK, MREQ|LWR|B(0)});
    tbl.push_back('{SEL|MACK, MREQ|LWR|B(1)});
    tbl.push_back('{SEL|KILL|MACK, MKILL|B(2)});
    tbl.push_back('{SEL, NONE});
    // dmem_sel dropped during miss write-back aborts it
    tbl.push_back('{REQ|SEL, NONE});
    tbl.push_back('{SEL|LV|VCEVD, NONE});
    tbl.push_back('{MACK, MKILL|SRC});
    tbl.push_back('{SEL, NONE});
    // flush: main line 2 dirty, VC entry 1 dirty
    tbl.push_back('{FLUSH|SEL, NONE});
    tbl.push_back('{SEL, EI(0)});
    tbl.push_back('{SEL, EI(1)});
    tbl.push_back('{SEL, EI(1)});
    tbl.push_back('{SEL, EI(2)});
    tbl.push_back('{SEL|MDRT, EI(2)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|EI(2)|B(0)});
    tbl.push_back('{MACK, MREQ|MWR|EI(2)|B(1)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|EI(2)|B(2)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|EI(2)|B(3)|LCLN});
    tbl.push_back('{SEL, EI(3)});
    tbl.push_back('{SEL, EI(3)});
    tbl.push_back('{SEL, EI(3)});
    tbl.push_back('{SEL, EI(3)});
    tbl.push_back('{SEL, EI(3)|VI(1)});
    tbl.push_back('{SEL|VCDRT, EI(3)|VI(1)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|EI(3)|VI(1)|B(0)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|EI(3)|VI(1)|B(1)});
    tbl.push_back('{SEL|MACK, MREQ|MWR|SRC|EI(3)|VI(1)|B(2)});
    tbl.push_back('{SEL|MACK,
                    MREQ|MWR|SRC|EI(3)|VI(1)|B(3)|VCLN});
    tbl.push_back('{SEL, EI(3)|VI(1)});
    tbl.push_back('{SEL, EI(3)|VI(1)});
    tbl.push_back('{SEL, ACK|EI(3)|VI(1)});
    tbl.push_back('{SEL, NONE});

    @(negedge clk);
    #1;
    check("reset", NONE);
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // flush with dmem_sel low throughout, dirty bits from a model
    mdirty = '{1'b0, 1'b1, 1'b0, 1'b0};
    vdirty = '{1'b1, 1'b0};
    acks = 0; cleans = 0; kills = 0;
    lc_idx = -1; vc_idx = -1;
    done = 1'b0;
    @(negedge clk);
    drive(FLUSH);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      drive(MACK);
      bus.main_dirty_i = mdirty[bus.evict_index_o];
      bus.vc_dirty_i   = vdirty[bus.vc_index_o];
      #1;
      if (bus.dcache2mem_kill_o) kills++;
      if (bus.cache_line_clean_o) begin
        cleans++;
        lc_idx = int'(bus.evict_index_o);
        mdirty[bus.evict_index_o] = 1'b0;
      end
      if (bus.vc_clean_o) begin
        cleans++;
        vc_idx = int'(bus.vc_index_o);
        vdirty[bus.vc_index_o] = 1'b0;
      end
      if (bus.dcache2lsummu_ack_o) begin
        acks++;
        done = 1'b1;
      end
    end
    check_int("nosel_flush_done", int'(done), 1);
    check_int("nosel_flush_acks", acks, 1);
    check_int("nosel_flush_cleans", cleans, 2);
    check_int("nosel_main_clean_idx", lc_idx, 1);
    check_int("nosel_vc_clean_idx", vc_idx, 0);
    check_int("nosel_flush_kills", kills, 0);
    apply(NOIN, NONE, "nosel_flush_idle");

    // reset asserted in the middle of a write-back
    apply(REQ|SEL, NONE, "rst_wb_req");
    apply(SEL|LV|VCEVD, NONE, "rst_wb_lookup");
    apply(SEL|MACK, MREQ|MWR|SRC|B(0), "rst_wb_beat0");
    apply(SEL, MREQ|MWR|SRC|B(1), "rst_wb_beat1");
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_wb", NONE);
    @(negedge clk);
    rst = 1'b0;
    apply(SEL, NONE, "rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
